me_search_ctrl: RTL and testbench

- Full-search motion-estimation controller for the 16x16 SAD reuse tree.
- Sequences candidate motion vectors over a square search window, one per cycle, and drives the 4x4 SAD units feeding the tree.
- Tracks tree latency with a tagged valid delay line and keeps a running minimum of the 16x16 SAD.
- Reports the best SAD and motion vector with a one-cycle done pulse.

---
 rtl/me_search_ctrl.sv | 141 ++++++++++++++
 tb/tb_me_search_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/me_search_ctrl.sv
// rtl/me_search_ctrl.sv - full-search motion-estimation candidate sequencer and 16x16 SAD minimum tracker
`timescale 1ns/1ps
module me_search_ctrl #(
  parameter int RANGE = 8,
  parameter int LAT   = 3,
  parameter int SAD_W = 16,
  parameter int CW    = $clog2(RANGE) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             hold,
  output logic             cand_valid,
  output logic [CW-1:0]    cand_x,
  output logic [CW-1:0]    cand_y,
  input  logic [SAD_W-1:0] sad_in,
  output logic             busy,
  output logic             done,
  output logic [SAD_W-1:0] best_sad,
  output logic [CW-1:0]    best_mvx,
  output logic [CW-1:0]    best_mvy
);

  localparam logic [CW-1:0] C_MIN = CW'(-RANGE);
  localparam logic [CW-1:0] C_MAX = CW'(RANGE - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CW-1:0]    r_x;
  logic [CW-1:0]    r_y;
  logic             r_first;
  logic             r_dv [LAT];
  logic [CW-1:0]    r_dx [LAT];
  logic [CW-1:0]    r_dy [LAT];
  logic [SAD_W-1:0] r_best_sad;
  logic [CW-1:0]    r_best_x;
  logic [CW-1:0]    r_best_y;
  logic             w_last;
  logic             w_pending;
  logic             w_take;

  assign w_last = (r_x == C_MAX) && (r_y == C_MAX);
  assign w_take = r_dv[LAT-1] && (r_first || (sad_in < r_best_sad));

  // The exiting stage retires this cycle, so only the younger stages keep DRAIN alive.
  always_comb begin
    w_pending = 1'b0;
    for (int i = 0; i < LAT - 1; i++) begin
      w_pending = w_pending | r_dv[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_ISSUE;
      S_ISSUE: if (!hold && w_last) w_next = S_DRAIN;
      S_DRAIN: if (!w_pending) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    cand_valid = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (r_state)
      S_ISSUE: begin
        cand_valid = !hold;
        busy       = 1'b1;
      end
      S_DRAIN: busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // The delay line shifts unconditionally: the SAD tree has no stall input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x        <= C_MIN;
      r_y        <= C_MIN;
      r_first    <= 1'b0;
      r_best_sad <= '1;
      r_best_x   <= '0;
      r_best_y   <= '0;
      for (int i = 0; i < LAT; i++) begin
        r_dv[i] <= 1'b0;
        r_dx[i] <= '0;
        r_dy[i] <= '0;
      end
    end else begin
      r_dv[0] <= cand_valid;
      r_dx[0] <= r_x;
      r_dy[0] <= r_y;
      for (int i = 1; i < LAT; i++) begin
        r_dv[i] <= r_dv[i-1];
        r_dx[i] <= r_dx[i-1];
        r_dy[i] <= r_dy[i-1];
      end
      if (w_take) begin
        r_best_sad <= sad_in;
        r_best_x   <= r_dx[LAT-1];
        r_best_y   <= r_dy[LAT-1];
        r_first    <= 1'b0;
      end
      if (r_state == S_IDLE && start) begin
        r_x        <= C_MIN;
        r_y        <= C_MIN;
        r_best_sad <= '1;
        r_first    <= 1'b1;
      end else if (cand_valid) begin
        // y wraps naturally to -RANGE after the last row.
        if (r_x == C_MAX) begin
          r_x <= C_MIN;
          r_y <= r_y + CW'(1);
        end else begin
          r_x <= r_x + CW'(1);
        end
      end
    end
  end

  assign cand_x   = r_x;
  assign cand_y   = r_y;
  assign best_sad = r_best_sad;
  assign best_mvx = r_best_x;
  assign best_mvy = r_best_y;

endmodule

// File: tb/tb_me_search_ctrl.sv
// tb/tb_me_search_ctrl.sv - table-driven bench for me_search_ctrl with a behavioural SAD tree
`timescale 1ns/1ps
module tb_me_search_ctrl;

  localparam int RANGE = 8;
  localparam int LAT   = 3;
  localparam int SAD_W = 16;
  localparam int CW    = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic             hold;
  logic             cand_valid;
  logic [CW-1:0]    cand_x;
  logic [CW-1:0]    cand_y;
  logic [SAD_W-1:0] sad_in;
  logic             busy;
  logic             done;
  logic [SAD_W-1:0] best_sad;
  logic [CW-1:0]    best_mvx;
  logic [CW-1:0]    best_mvy;

  always #5 clk = ~clk;

  me_search_ctrl #(.RANGE(RANGE), .LAT(LAT), .SAD_W(SAD_W), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .hold(hold),
    .cand_valid(cand_valid), .cand_x(cand_x), .cand_y(cand_y),
    .sad_in(sad_in), .busy(busy), .done(done),
    .best_sad(best_sad), .best_mvx(best_mvx), .best_mvy(best_mvy)
  );

  typedef struct {
    int mode;
    int hold_at;
    int hold_len;
    int extra;
    bit chained;
    int e_sad;
    int e_x;
    int e_y;
    int e_done;
    int e_nv;
  } vec_t;

  vec_t tbl [10];

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int s0 = 0;
  int mode = 0;
  int vidx = 0, vcnt = 0, rerr = 0, hviol = 0;
  int done_cnt = 0, done_cyc = -1;
  int snap_sad = -1, snap_x = -1, snap_y = -1, snap_busy = -1;
  bit n_v = 1'b0;
  int n_x = 0, n_y = 0;
  bit p_v [LAT] = '{default: 1'b0};
  int p_x [LAT] = '{default: 0};
  int p_y [LAT] = '{default: 0};

  function automatic int iabs(input int a);
    return (a < 0) ? -a : a;
  endfunction

  function automatic int sad_f(input int m, input int x, input int y);
    case (m)
      0: return 1000 + 10 * iabs(x - 3) + 10 * iabs(y + 2);
      1: return ((x == -1 && y == -4) || (x == 2 && y == 5)) ? 500 : 900;
      2: return 65535;
      3: return 1200 + 7 * iabs(x + 5) + 3 * iabs(y - 6);
      default: return 2000 - ((y + 8) * 16 + (x + 8));
    endcase
  endfunction

  // SAD tree model: returns the SAD of the candidate issued LAT cycles earlier, zero otherwise.
  always @(posedge clk) begin
    cyc    <= cyc + 1;
    p_v[0] <= n_v;
    p_x[0] <= n_x;
    p_y[0] <= n_y;
    for (int i = 1; i < LAT; i++) begin
      p_v[i] <= p_v[i-1];
      p_x[i] <= p_x[i-1];
      p_y[i] <= p_y[i-1];
    end
  end

  always_comb begin
    sad_in = '0;
    if (p_v[LAT-1]) sad_in = SAD_W'(sad_f(mode, p_x[LAT-1], p_y[LAT-1]));
  end

  always @(negedge clk) begin
    n_v = cand_valid;
    n_x = $signed(cand_x);
    n_y = $signed(cand_y);
    if (cand_valid) begin
      if (n_x != (vidx % 16) - 8 || n_y != (vidx / 16) - 8) rerr++;
      if (hold) hviol++;
      vidx++;
      vcnt++;
    end
    if (done) begin
      done_cnt++;
      done_cyc  = cyc - s0;
      snap_sad  = best_sad;
      snap_x    = $signed(best_mvx);
      snap_y    = $signed(best_mvy);
      snap_busy = busy;
    end
  end

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic clear_mon();
    vidx = 0; vcnt = 0; rerr = 0; hviol = 0;
    done_cnt = 0; done_cyc = -1;
    snap_sad = -1; snap_x = -1; snap_y = -1; snap_busy = -1;
  endtask

  task automatic run_vec(input vec_t v, input bit chain_next, input int id);
    int rel;
    if (!v.chained) begin
      @(posedge clk);
      #1;
    end
    mode  = v.mode;
    start = 1'b1;
    hold  = 1'b0;
    s0    = cyc;
    clear_mon();
    rel = 0;
    while (rel < 600) begin
      @(posedge clk);
      #1;
      rel   = cyc - s0;
      start = (rel == v.extra);
      hold  = (rel >= v.hold_at) && (rel < v.hold_at + v.hold_len);
      if (chain_next && done_cnt == 1 && rel == done_cyc + 1) break;
      if (done_cnt > 0 && rel >= done_cyc + 5) break;
    end
    hold  = 1'b0;
    start = 1'b0;
    check($sformatf("v%0d best_sad", id), snap_sad, v.e_sad);
    check($sformatf("v%0d best_mvx", id), snap_x, v.e_x);
    check($sformatf("v%0d best_mvy", id), snap_y, v.e_y);
    check($sformatf("v%0d done_cycle", id), done_cyc, v.e_done);
    check($sformatf("v%0d done_count", id), done_cnt, 1);
    check($sformatf("v%0d valid_count", id), vcnt, v.e_nv);
    check($sformatf("v%0d raster_errors", id), rerr, 0);
    check($sformatf("v%0d valid_during_hold", id), hviol, 0);
    check($sformatf("v%0d busy_at_done", id), snap_busy, 0);
    if (!chain_next) begin
      check($sformatf("v%0d idle_after_done", id), busy, 0);
      check($sformatf("v%0d best_sad_held", id), best_sad, v.e_sad);
    end
  endtask

  initial begin
    int rel;
    tbl[0] = '{0, -1, 0, -1,  0, 1000,  3, -2, 260, 256};
    tbl[1] = '{1, -1, 0, -1,  0, 500,  -1, -4, 260, 256};
    tbl[2] = '{2, -1, 0, -1,  0, 65535,-8, -8, 260, 256};
    tbl[3] = '{0, 40, 5, -1,  0, 1000,  3, -2, 265, 256};
    tbl[4] = '{0, -1, 0, 100, 0, 1000,  3, -2, 260, 256};
    tbl[5] = '{4, -1, 0, -1,  0, 1745,  7,  7, 260, 256};
    tbl[6] = '{0, 255, 3, -1, 0, 1000,  3, -2, 263, 256};
    tbl[7] = '{0, -1, 0, 260, 0, 1000,  3, -2, 260, 256};
    tbl[8] = '{0, -1, 0, -1,  0, 1000,  3, -2, 260, 256};
    tbl[9] = '{3, -1, 0, -1,  1, 1200, -5,  6, 260, 256};

    rst_n = 1'b0;
    start = 1'b0;
    hold  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset cand_valid", cand_valid, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset best_sad", best_sad, 65535);
    check("reset best_mvx", $signed(best_mvx), 0);
    check("reset cand_x", $signed(cand_x), -8);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      if (i < 9) run_vec(tbl[i], tbl[i+1].chained, i);
      else       run_vec(tbl[i], 1'b0, i);
    end

    // Abort mid-search with reset, then confirm a clean search afterwards.
    @(posedge clk);
    #1;
    mode  = 0;
    start = 1'b1;
    s0    = cyc;
    clear_mon();
    rel = 0;
    while (rel < 450) begin
      @(posedge clk);
      #1;
      rel   = cyc - s0;
      start = 1'b0;
      if (rel == 150) begin
        rst_n = 1'b0;
        @(negedge clk);
        check("abort busy", busy, 0);
        check("abort cand_valid", cand_valid, 0);
        check("abort best_sad", best_sad, 65535);
        check("abort done", done, 0);
        check("abort cand_y", $signed(cand_y), -8);
      end
      if (rel == 152) rst_n = 1'b1;
    end
    check("abort no_done", done_cnt, 0);
    check("abort idle", busy, 0);
    check("abort best_sad_after", best_sad, 65535);
    run_vec(tbl[0], 1'b0, 10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
